// File: rtl/nonce_result_arbiter_pkg.sv
// Shared definitions for the nonce result arbiter: default sizes and the
// elaboration-time helpers used to size ports and storage.
package nonce_result_arbiter_pkg;

    localparam int NUM_CORES_DEF  = 4;
    localparam int FIFO_DEPTH_DEF = 4;
    localparam int NONCE_W_DEF    = 40;
    localparam int DIFY_W_DEF     = 32;

    // Ceiling log2, evaluated at elaboration only (returns 0 for value <= 1).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Width of one stored result: {source core, id/nonce, difficulty}.
    function automatic int entry_w(input int num_cores, input int nonce_w, input int dify_w);
        return clog2(num_cores) + nonce_w + dify_w;
    endfunction

endpackage

// File: rtl/nonce_result_arbiter_result_fifo.sv
// Show-ahead synchronous FIFO with flush and occupancy count. The head entry
// is read combinationally so it is usable in the same cycle head_valid rises;
// an empty FIFO presents zero on its head.
module result_fifo
    import nonce_result_arbiter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   srst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic                   head_valid,
    output logic [WIDTH-1:0]       head_data,
    output logic [clog2(DEPTH):0]  count,
    output logic                   not_empty
);

    localparam int PTR_W   = (DEPTH > 1) ? clog2(DEPTH) : 1;
    localparam int COUNT_W = clog2(DEPTH) + 1;

    logic [WIDTH-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [COUNT_W-1:0] count_reg, count_next;
    logic               not_empty_reg;
    logic               pop_ok, push_ok;

    // Pop on empty is ignored; a push into a full FIFO is only taken alongside a pop.
    assign pop_ok  = pop && (count_reg != '0);
    assign push_ok = push && ((count_reg < COUNT_W'(DEPTH)) || pop_ok);

    // Pointer and occupancy update; flush overrides any push or pop.
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_next = (wr_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_reg + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_next = (rd_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_reg + PTR_W'(1);
            end
            if (push_ok && !pop_ok) begin
                count_next = count_reg + COUNT_W'(1);
            end else if (pop_ok && !push_ok) begin
                count_next = count_reg - COUNT_W'(1);
            end
        end
    end

    // Control state; the interrupt flag tracks next occupancy so it lines up with count.
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            not_empty_reg <= 1'b0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            count_reg     <= count_next;
            not_empty_reg <= (count_next != '0);
        end
    end

    // Storage is not reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    assign head_valid = (count_reg != '0);
    assign head_data  = head_valid ? mem[rd_ptr_reg] : '0;
    assign count      = count_reg;
    assign not_empty  = not_empty_reg;

endmodule

// File: rtl/nonce_result_arbiter.sv
// Round-robin collector of nonce-found results from the hash cores into one
// show-ahead result FIFO. A core is acked for exactly one cycle after its
// result is written; the ack also masks it so it is not taken twice.
module nonce_result_arbiter
    import nonce_result_arbiter_pkg::*;
#(
    parameter int NUM_CORES  = NUM_CORES_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int NONCE_W    = NONCE_W_DEF,
    parameter int DIFY_W     = DIFY_W_DEF
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_CORES-1:0]            core_valid,
    input  logic [NUM_CORES*NONCE_W-1:0]    core_id_nonce,
    input  logic [NUM_CORES*DIFY_W-1:0]     core_hash_dify,
    output logic [NUM_CORES-1:0]            core_ack,
    input  logic                            flush,
    input  logic                            rd_pop,
    output logic                            rd_valid,
    output logic [clog2(NUM_CORES)-1:0]     rd_core,
    output logic [NONCE_W-1:0]              rd_id_nonce,
    output logic [DIFY_W-1:0]               rd_hash_dify,
    output logic [clog2(FIFO_DEPTH):0]      fifo_count,
    output logic                            irq
);

    localparam int CORE_W  = clog2(NUM_CORES);
    localparam int COUNT_W = clog2(FIFO_DEPTH) + 1;
    localparam int ENTRY_W = entry_w(NUM_CORES, NONCE_W, DIFY_W);

    logic [NUM_CORES-1:0] core_ack_reg, core_ack_next;
    logic [NUM_CORES-1:0] eligible;
    logic [CORE_W-1:0]    last_grant_reg, last_grant_next;
    logic [CORE_W-1:0]    grant_idx, cand;
    logic                 grant_found, space, push;
    logic [ENTRY_W-1:0]   push_entry, head_entry;

    // A core still being acked has already been taken and is masked off.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CORES; gi++) begin : g_elig
            assign eligible[gi] = core_valid[gi] & ~core_ack_reg[gi];
        end
    endgenerate

    // Room exists if not full, or if the head leaves in the same cycle.
    assign space = (fifo_count < COUNT_W'(FIFO_DEPTH)) || (rd_pop && rd_valid);

    // Round-robin search starting just after the last granted core.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 1; i <= NUM_CORES; i++) begin
            cand = last_grant_reg + CORE_W'(i);
            if (!grant_found && eligible[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign push       = grant_found && space && !flush;
    assign push_entry = {grant_idx,
                         core_id_nonce[grant_idx*NONCE_W +: NONCE_W],
                         core_hash_dify[grant_idx*DIFY_W +: DIFY_W]};

    // Next ack and priority pointer; both only move on an actual write.
    always_comb begin
        core_ack_next   = '0;
        last_grant_next = last_grant_reg;
        if (push) begin
            core_ack_next[grant_idx] = 1'b1;
            last_grant_next          = grant_idx;
        end
    end

    // Ack and pointer registers; reset hands first priority to core 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            core_ack_reg   <= '0;
            last_grant_reg <= CORE_W'(NUM_CORES - 1);
        end else begin
            core_ack_reg   <= core_ack_next;
            last_grant_reg <= last_grant_next;
        end
    end

    result_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_result_fifo (
        .clk        (clk),
        .srst       (reset),
        .push       (push),
        .push_data  (push_entry),
        .pop        (rd_pop),
        .flush      (flush),
        .head_valid (rd_valid),
        .head_data  (head_entry),
        .count      (fifo_count),
        .not_empty  (irq)
    );

    assign core_ack = core_ack_reg;
    assign {rd_core, rd_id_nonce, rd_hash_dify} = head_entry;

endmodule

// File: tb/tb_nonce_result_arbiter.sv
// Self-checking bench for nonce_result_arbiter: directed scenarios plus a
// randomized run compared against a queue-based reference model.
module tb_nonce_result_arbiter;

    localparam int N  = 4;
    localparam int D  = 4;
    localparam int NW = 40;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    core_valid;
    logic [N*NW-1:0] core_id_nonce;
    logic [N*DW-1:0] core_hash_dify;
    logic [N-1:0]    core_ack;
    logic            flush;
    logic            rd_pop;
    logic            rd_valid;
    logic [1:0]      rd_core;
    logic [NW-1:0]   rd_id_nonce;
    logic [DW-1:0]   rd_hash_dify;
    logic [2:0]      fifo_count;
    logic            irq;

    nonce_result_arbiter #(
        .NUM_CORES (N), .FIFO_DEPTH (D), .NONCE_W (NW), .DIFY_W (DW)
    ) dut (
        .clk (clk), .reset (reset), .core_valid (core_valid),
        .core_id_nonce (core_id_nonce), .core_hash_dify (core_hash_dify),
        .core_ack (core_ack), .flush (flush), .rd_pop (rd_pop),
        .rd_valid (rd_valid), .rd_core (rd_core), .rd_id_nonce (rd_id_nonce),
        .rd_hash_dify (rd_hash_dify), .fifo_count (fifo_count), .irq (irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: results as a plain queue, ack and priority as simple state.
    typedef struct {
        int            core;
        logic [NW-1:0] nonce;
        logic [DW-1:0] dify;
    } ent_t;

    ent_t         mq[$];
    logic [N-1:0] m_ack;
    int           m_lg;
    int           proto_mode;   // 0: drop valid after ack, 1: random, 2: always re-present

    task automatic set_core(input int k, input logic [NW-1:0] nonce, input logic [DW-1:0] dify);
        core_id_nonce[k*NW +: NW] = nonce;
        core_hash_dify[k*DW +: DW] = dify;
    endtask

    task automatic new_result(input int k);
        logic [NW-1:0] n;
        n = {8'(k), 32'($urandom)};
        set_core(k, n, 32'($urandom));
    endtask

    task automatic model_edge();
        logic [N-1:0] nack;
        bit           popping;
        int           pick;
        int           k;
        ent_t         e;
        nack = '0;
        pick = -1;
        if (reset) begin
            mq.delete();
            m_ack = '0;
            m_lg  = N - 1;
        end else if (flush) begin
            mq.delete();
            m_ack = '0;
        end else begin
            popping = rd_pop && (mq.size() > 0);
            if (mq.size() < D || popping) begin
                for (int i = 1; i <= N; i++) begin
                    k = (m_lg + i) % N;
                    if (pick < 0 && core_valid[k] && !m_ack[k]) pick = k;
                end
            end
            if (popping) void'(mq.pop_front());
            if (pick >= 0) begin
                e.core  = pick;
                e.nonce = core_id_nonce[pick*NW +: NW];
                e.dify  = core_hash_dify[pick*DW +: DW];
                mq.push_back(e);
                m_lg       = pick;
                nack[pick] = 1'b1;
            end
            m_ack = nack;
        end
    endtask

    // One clock: advance the model, clear strobes, then let acked cores react.
    task automatic cycle();
        logic [N-1:0] acked;
        acked = m_ack;
        @(posedge clk);
        #1;
        model_edge();
        rd_pop = 1'b0;
        flush  = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (acked[k]) begin
                if (proto_mode == 0 || (proto_mode == 1 && $urandom_range(0, 1) == 0)) begin
                    core_valid[k] = 1'b0;
                end else begin
                    new_result(k);
                end
            end else if (proto_mode == 1 && !core_valid[k] && $urandom_range(0, 2) == 0) begin
                core_valid[k] = 1'b1;
                new_result(k);
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        core_valid = '0; core_id_nonce = '0; core_hash_dify = '0;
        flush = 0; rd_pop = 0; proto_mode = 0; m_ack = '0; m_lg = N - 1;
        do_reset();
        checks++;
        if (core_ack !== 4'b0 || rd_valid !== 1'b0 || fifo_count !== 3'd0 || irq !== 1'b0 ||
            rd_core !== 2'd0 || rd_id_nonce !== 40'd0 || rd_hash_dify !== 32'd0) begin
            errors++;
            $display("FAIL reset_state got ack=%b valid=%b count=%0d irq=%b head=%0d/%h/%h want all zero",
                     core_ack, rd_valid, fifo_count, irq, rd_core, rd_id_nonce, rd_hash_dify);
        end
        $display("test_reset done");
    endtask

    task automatic test_single();
        do_reset();
        proto_mode = 0;
        set_core(2, 40'h02_1234ABCD, 32'h0000FFFF);
        core_valid = 4'b0100;
        cycle();
        checks++;
        if (core_ack !== 4'b0100 || rd_valid !== 1'b1 || rd_core !== 2'd2 || fifo_count !== 3'd1 || irq !== 1'b1) begin
            errors++;
            $display("FAIL single_grant got ack=%b valid=%b core=%0d count=%0d irq=%b want 0100/1/2/1/1",
                     core_ack, rd_valid, rd_core, fifo_count, irq);
        end
        checks++;
        if (rd_id_nonce !== 40'h02_1234ABCD || rd_hash_dify !== 32'h0000FFFF) begin
            errors++;
            $display("FAIL single_data got %h/%h want 021234abcd/0000ffff", rd_id_nonce, rd_hash_dify);
        end
        rd_pop = 1'b1;
        cycle();
        checks++;
        if (core_ack !== 4'b0 || rd_valid !== 1'b0 || fifo_count !== 3'd0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL single_pop got ack=%b valid=%b count=%0d irq=%b want 0000/0/0/0",
                     core_ack, rd_valid, fifo_count, irq);
        end
        $display("test_single done");
    endtask

    task automatic test_round_robin();
        logic [N-1:0] want;
        proto_mode = 2;
        for (int k = 0; k < N; k++) new_result(k);
        core_valid = 4'b1111;
        do_reset();
        for (int i = 0; i < N; i++) begin
            cycle();
            want = 4'(1 << i);
            checks++;
            if (core_ack !== want || fifo_count !== 3'(i + 1)) begin
                errors++;
                $display("FAIL rr_fill step=%0d got ack=%b count=%0d want ack=%b count=%0d",
                         i, core_ack, fifo_count, want, i + 1);
            end
        end
        cycle();
        checks++;
        if (core_ack !== 4'b0 || fifo_count !== 3'd4) begin
            errors++;
            $display("FAIL rr_full_stall got ack=%b count=%0d want 0000/4", core_ack, fifo_count);
        end
        for (int j = 0; j < 6; j++) begin
            rd_pop = 1'b1;
            cycle();
            want = 4'(1 << (j % N));
            checks++;
            if (core_ack !== want || fifo_count !== 3'd4 || rd_core !== 2'((j + 1) % N) ||
                rd_id_nonce !== mq[0].nonce) begin
                errors++;
                $display("FAIL rr_pop_push step=%0d got ack=%b count=%0d head=%0d want ack=%b count=4 head=%0d",
                         j, core_ack, fifo_count, rd_core, want, (j + 1) % N);
            end
        end
        $display("test_round_robin done");
    endtask

    task automatic test_backpressure();
        proto_mode = 2;
        core_valid = 4'b0000;
        do_reset();
        for (int k = 0; k < N; k++) new_result(k);
        core_valid = 4'b1101;
        repeat (4) cycle();   // grants 0,2,3,0
        checks++;
        if (fifo_count !== 3'd4) begin
            errors++;
            $display("FAIL bp_fill got count=%0d want 4", fifo_count);
        end
        core_valid[1] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++;
            if (core_ack[1] !== 1'b0 || fifo_count !== 3'd4) begin
                errors++;
                $display("FAIL bp_stall cyc=%0d got ack=%b count=%0d want ack1=0 count=4", i, core_ack, fifo_count);
            end
        end
        rd_pop = 1'b1;
        cycle();
        checks++;
        if (core_ack !== 4'b0010 || fifo_count !== 3'd4) begin
            errors++;
            $display("FAIL bp_pop_push got ack=%b count=%0d want 0010/4", core_ack, fifo_count);
        end
        $display("test_backpressure done");
    endtask

    task automatic test_underflow_flush();
        proto_mode = 0;
        core_valid = 4'b0000;
        do_reset();
        rd_pop = 1'b1;
        cycle();
        checks++;
        if (fifo_count !== 3'd0 || rd_valid !== 1'b0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL underflow got count=%0d valid=%b irq=%b want 0/0/0", fifo_count, rd_valid, irq);
        end
        for (int k = 0; k < 3; k++) new_result(k);
        core_valid = 4'b0111;
        repeat (3) cycle();   // grants 0,1,2; last_grant = 2
        checks++;
        if (fifo_count !== 3'd3 || core_ack !== 4'b0100) begin
            errors++;
            $display("FAIL flush_setup got count=%0d ack=%b want 3/0100", fifo_count, core_ack);
        end
        new_result(0);
        new_result(3);
        core_valid[0] = 1'b1;
        core_valid[3] = 1'b1;
        flush = 1'b1;
        cycle();
        checks++;
        if (fifo_count !== 3'd0 || core_ack !== 4'b0 || rd_valid !== 1'b0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL flush_clear got count=%0d ack=%b valid=%b irq=%b want 0/0000/0/0",
                     fifo_count, core_ack, rd_valid, irq);
        end
        cycle();
        checks++;
        if (core_ack !== 4'b1000 || fifo_count !== 3'd1 || rd_core !== 2'd3) begin
            errors++;
            $display("FAIL flush_resume got ack=%b count=%0d core=%0d want 1000/1/3", core_ack, fifo_count, rd_core);
        end
        cycle();
        checks++;
        if (core_ack !== 4'b0001 || fifo_count !== 3'd2) begin
            errors++;
            $display("FAIL flush_resume2 got ack=%b count=%0d want 0001/2", core_ack, fifo_count);
        end
        $display("test_underflow_flush done");
    endtask

    task automatic test_reset_mid();
        proto_mode = 0;
        core_valid = 4'b0000;
        do_reset();
        new_result(1);
        core_valid = 4'b0010;
        cycle();
        new_result(0);
        core_valid[0] = 1'b1;
        cycle();
        checks++;
        if (fifo_count !== 3'd2 || core_ack !== 4'b0001) begin
            errors++;
            $display("FAIL mid_setup got count=%0d ack=%b want 2/0001", fifo_count, core_ack);
        end
        do_reset();
        checks++;
        if (core_ack !== 4'b0 || rd_valid !== 1'b0 || fifo_count !== 3'd0 || irq !== 1'b0 ||
            rd_core !== 2'd0 || rd_id_nonce !== 40'd0 || rd_hash_dify !== 32'd0) begin
            errors++;
            $display("FAIL mid_reset got ack=%b valid=%b count=%0d irq=%b head=%0d/%h/%h want all zero",
                     core_ack, rd_valid, fifo_count, irq, rd_core, rd_id_nonce, rd_hash_dify);
        end
        new_result(0);
        new_result(1);
        core_valid = 4'b0011;
        cycle();
        checks++;
        if (core_ack !== 4'b0001 || rd_core !== 2'd0) begin
            errors++;
            $display("FAIL mid_first_grant got ack=%b core=%0d want 0001/0", core_ack, rd_core);
        end
        $display("test_reset_mid done");
    endtask

    task automatic test_random();
        int pop_pct;
        proto_mode = 1;
        core_valid = 4'b0000;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            pop_pct = (c < 300) ? 25 : 75;
            rd_pop  = ($urandom_range(0, 99) < pop_pct);
            flush   = ($urandom_range(0, 39) == 0);
            cycle();
            checks++;
            if (core_ack !== m_ack || fifo_count !== 3'(mq.size()) ||
                rd_valid !== (mq.size() != 0) || irq !== (mq.size() != 0)) begin
                errors++;
                $display("FAIL rand_ctrl cyc=%0d got ack=%b count=%0d valid=%b irq=%b want ack=%b count=%0d",
                         c, core_ack, fifo_count, rd_valid, irq, m_ack, mq.size());
            end
            if (mq.size() != 0) begin
                checks++;
                if (rd_core !== 2'(mq[0].core) || rd_id_nonce !== mq[0].nonce || rd_hash_dify !== mq[0].dify) begin
                    errors++;
                    $display("FAIL rand_head cyc=%0d got %0d/%h/%h want %0d/%h/%h", c, rd_core, rd_id_nonce,
                             rd_hash_dify, mq[0].core, mq[0].nonce, mq[0].dify);
                end
            end
        end
        $display("test_random done");
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_underflow_flush();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
